// File: rtl/dvp_pkg.sv
// Shared types for the DVP capture path: capture FSM encoding, default
// coordinate width and the Bayer phase enum used by the timing generator.
package dvp_pkg;

    localparam int CW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        CAPT = 2'd2
    } cap_state_e;

    typedef enum logic [1:0] {
        BAYER_RGGB = 2'd0,
        BAYER_BGGR = 2'd1,
        BAYER_GRBG = 2'd2,
        BAYER_GBRG = 2'd3
    } bayer_e;

endpackage

// File: rtl/dvp_edge_det.sv
// Registers a DVP control line and flags its transitions into and out of the
// active level POL, all aligned with the registered level.
module dvp_edge_det #(
    parameter logic POL = 1'b1
) (
    input  logic xclk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic cur_reg;
    logic prev_reg;

    // Both stages reset to the inactive level so no edge is seen out of reset.
    always_ff @(posedge xclk or negedge reset_n) begin
        if (!reset_n) begin
            cur_reg  <= ~POL;
            prev_reg <= ~POL;
        end else begin
            cur_reg  <= din;
            prev_reg <= cur_reg;
        end
    end

    assign level = (cur_reg == POL);
    assign rise  = (cur_reg == POL) && (prev_reg != POL);
    assign fall  = (cur_reg != POL) && (prev_reg == POL);

endmodule

// File: rtl/dvp_capture_ctrl.sv
// Frame-capture sequencer: arms on command, aligns to vsync, crops a window
// out of the DVP raw stream and tags it with SOF/EOL/EOF markers.
module dvp_capture_ctrl
    import dvp_pkg::*;
#(
    parameter int   BITS  = 8,
    parameter logic V_POL = 1'b1,
    parameter int   CW    = CW_DEFAULT
) (
    input  logic            xclk,
    input  logic            reset_n,
    input  logic            cfg_start,
    input  logic            cfg_stop,
    input  logic            cfg_continuous,
    input  logic [CW-1:0]   cfg_crop_x,
    input  logic [CW-1:0]   cfg_crop_y,
    input  logic [CW-1:0]   cfg_crop_w,
    input  logic [CW-1:0]   cfg_crop_h,
    input  logic            in_vsync,
    input  logic            in_href,
    input  logic [BITS-1:0] in_raw,
    output logic            out_valid,
    output logic [BITS-1:0] out_data,
    output logic            out_sof,
    output logic            out_eol,
    output logic            out_eof,
    output logic            busy,
    output logic            frame_done,
    output logic [CW-1:0]   frame_cnt,
    output logic            err_short
);

    logic vs_lvl, vs_act, vs_deact;
    logic href_lvl, href_rise, href_fall;

    dvp_edge_det #(.POL(V_POL)) u_vs_det (
        .xclk(xclk), .reset_n(reset_n), .din(in_vsync),
        .level(vs_lvl), .rise(vs_act), .fall(vs_deact)
    );

    dvp_edge_det #(.POL(1'b1)) u_href_det (
        .xclk(xclk), .reset_n(reset_n), .din(in_href),
        .level(href_lvl), .rise(href_rise), .fall(href_fall)
    );

    cap_state_e    state_reg, state_next;
    logic          stop_pend_reg, stop_pend_next;
    logic [CW-1:0] cx_reg, cx_next, cy_reg, cy_next, cw_reg, cw_next, ch_reg, ch_next;
    logic [CW-1:0] line_reg, line_next, pix_reg, pix_next;
    logic [CW-1:0] lines_full_reg, lines_full_next;
    logic          line_eol_reg, line_eol_next;
    logic [BITS-1:0] raw_reg;
    logic            ov_reg, ov_next, sof_reg, sof_next, eol_reg, eol_next, eof_reg, eof_next;
    logic [BITS-1:0] od_reg, od_next;
    logic          fd_reg, fd_next;
    logic [CW-1:0] fc_reg, fc_next;
    logic          err_reg, err_next;

    // Window bounds are one bit wider so x+w / y+h never wrap.
    logic [CW:0]   x_end, y_end;
    logic [CW-1:0] pix_cur;
    logic          line_act, row_in, col_in, in_win, is_sof, is_eol, is_eof;

    assign x_end    = {1'b0, cx_reg} + {1'b0, cw_reg};
    assign y_end    = {1'b0, cy_reg} + {1'b0, ch_reg};
    assign pix_cur  = href_rise ? '0 : pix_reg;
    // Line activity inside the vsync pulse is not part of the picture.
    assign line_act = href_lvl && !vs_lvl;
    assign row_in   = (line_reg >= cy_reg) && ({1'b0, line_reg} < y_end);
    assign col_in   = (pix_cur >= cx_reg) && ({1'b0, pix_cur} < x_end);
    assign in_win   = (state_reg == CAPT) && line_act && row_in && col_in;
    assign is_sof   = in_win && (line_reg == cy_reg) && (pix_cur == cx_reg);
    assign is_eol   = in_win && ({1'b0, pix_cur} == x_end - 1'b1);
    assign is_eof   = is_eol && ({1'b0, line_reg} == y_end - 1'b1);

    always_comb begin
        state_next      = state_reg;
        stop_pend_next  = stop_pend_reg;
        cx_next         = cx_reg;
        cy_next         = cy_reg;
        cw_next         = cw_reg;
        ch_next         = ch_reg;
        line_next       = line_reg;
        pix_next        = pix_reg;
        lines_full_next = lines_full_reg;
        line_eol_next   = line_eol_reg;
        fd_next         = 1'b0;
        fc_next         = fc_reg;
        err_next        = err_reg;
        ov_next         = in_win;
        od_next         = in_win ? raw_reg : '0;
        sof_next        = is_sof;
        eol_next        = is_eol;
        eof_next        = is_eof;

        case (state_reg)
            IDLE: begin
                if (cfg_start) begin
                    state_next     = ARM;
                    err_next       = 1'b0;
                    stop_pend_next = 1'b0;
                end
            end
            ARM: begin
                if (cfg_stop) begin
                    state_next = IDLE;
                end else if (vs_act) begin
                    state_next = CAPT;
                end
            end
            CAPT: begin
                if (cfg_stop) stop_pend_next = 1'b1;
                if (line_act) pix_next = pix_cur + 1'b1;
                if (is_eol) begin
                    lines_full_next = lines_full_reg + 1'b1;
                    line_eol_next   = 1'b1;
                end
                if (href_fall && !vs_lvl) begin
                    if (row_in && (cw_reg != '0) && !line_eol_reg) err_next = 1'b1;
                    line_next     = line_reg + 1'b1;
                    line_eol_next = 1'b0;
                end
                if (vs_act) begin
                    fd_next = 1'b1;
                    fc_next = fc_reg + 1'b1;
                    if ((cw_reg != '0) && (ch_reg != '0) && (lines_full_reg < ch_reg))
                        err_next = 1'b1;
                    if (stop_pend_reg || cfg_stop || !cfg_continuous) begin
                        state_next     = IDLE;
                        stop_pend_next = 1'b0;
                    end
                end
                if (vs_deact) begin
                    line_next       = '0;
                    lines_full_next = '0;
                    line_eol_next   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase

        // A vsync that opens a frame (from ARM or back-to-back) relatches the window.
        if (vs_act && state_next == CAPT) begin
            cx_next         = cfg_crop_x;
            cy_next         = cfg_crop_y;
            cw_next         = cfg_crop_w;
            ch_next         = cfg_crop_h;
            line_next       = '0;
            pix_next        = '0;
            lines_full_next = '0;
            line_eol_next   = 1'b0;
        end
    end

    always_ff @(posedge xclk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            stop_pend_reg  <= 1'b0;
            cx_reg         <= '0;
            cy_reg         <= '0;
            cw_reg         <= '0;
            ch_reg         <= '0;
            line_reg       <= '0;
            pix_reg        <= '0;
            lines_full_reg <= '0;
            line_eol_reg   <= 1'b0;
            raw_reg        <= '0;
            ov_reg         <= 1'b0;
            od_reg         <= '0;
            sof_reg        <= 1'b0;
            eol_reg        <= 1'b0;
            eof_reg        <= 1'b0;
            fd_reg         <= 1'b0;
            fc_reg         <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            stop_pend_reg  <= stop_pend_next;
            cx_reg         <= cx_next;
            cy_reg         <= cy_next;
            cw_reg         <= cw_next;
            ch_reg         <= ch_next;
            line_reg       <= line_next;
            pix_reg        <= pix_next;
            lines_full_reg <= lines_full_next;
            line_eol_reg   <= line_eol_next;
            raw_reg        <= in_raw;
            ov_reg         <= ov_next;
            od_reg         <= od_next;
            sof_reg        <= sof_next;
            eol_reg        <= eol_next;
            eof_reg        <= eof_next;
            fd_reg         <= fd_next;
            fc_reg         <= fc_next;
            err_reg        <= err_next;
        end
    end

    assign out_valid  = ov_reg;
    assign out_data   = od_reg;
    assign out_sof    = sof_reg;
    assign out_eol    = eol_reg;
    assign out_eof    = eof_reg;
    assign busy       = (state_reg != IDLE);
    assign frame_done = fd_reg;
    assign frame_cnt  = fc_reg;
    assign err_short  = err_reg;

endmodule

// File: tb/tb_dvp_capture_ctrl.sv
// Directed bench for dvp_capture_ctrl on a synthetic 8x4 frame, pixel value
// line*16+pix, with a table of crop windows and hand-written control sequences.
module tb_dvp_capture_ctrl;

    localparam int BITS = 8;
    localparam int CW   = 16;
    localparam int W    = 8;
    localparam int H    = 4;

    logic            xclk = 1'b0;
    logic            reset_n = 1'b0;
    logic            cfg_start = 1'b0, cfg_stop = 1'b0, cfg_continuous = 1'b0;
    logic [CW-1:0]   cfg_crop_x = '0, cfg_crop_y = '0, cfg_crop_w = '0, cfg_crop_h = '0;
    logic            in_vsync = 1'b0, in_href = 1'b0;
    logic [BITS-1:0] in_raw = '0;
    logic            out_valid, out_sof, out_eol, out_eof, busy, frame_done, err_short;
    logic [BITS-1:0] out_data;
    logic [CW-1:0]   frame_cnt;

    dvp_capture_ctrl #(.BITS(BITS), .V_POL(1'b1), .CW(CW)) dut (
        .xclk(xclk), .reset_n(reset_n),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_continuous(cfg_continuous),
        .cfg_crop_x(cfg_crop_x), .cfg_crop_y(cfg_crop_y),
        .cfg_crop_w(cfg_crop_w), .cfg_crop_h(cfg_crop_h),
        .in_vsync(in_vsync), .in_href(in_href), .in_raw(in_raw),
        .out_valid(out_valid), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt), .err_short(err_short)
    );

    always #5 xclk = ~xclk;

    typedef struct packed {
        logic       sof;
        logic       eol;
        logic       eof;
        logic [7:0] data;
    } beat_t;

    typedef struct {
        int x, y, w, h, short_l, exp_beats;
        bit exp_err;
    } vec_t;

    beat_t beats[$];
    beat_t expq[$];
    int    fd_cnt = 0;
    int    zero_viol = 0;
    int    checks = 0;
    int    failures = 0;
    int    exp_fc = 0;

    always @(negedge xclk) begin
        if (reset_n) begin
            if (out_valid) beats.push_back({out_sof, out_eol, out_eof, out_data});
            else if (out_data != '0) zero_viol++;
            if (frame_done) fd_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge xclk);
            #1;
        end
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic pulse_stop();
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
    endtask

    task automatic vsync_pulse();
        in_vsync = 1'b1;
        tick(20);
        in_vsync = 1'b0;
        tick(4);
    endtask

    // H lines of W pixels; line short_l is one pixel short, stop pulsed on line stop_l.
    task automatic send_lines(input int short_l, input int stop_l);
        for (int l = 0; l < H; l++) begin
            int lw;
            lw = (l == short_l) ? W - 1 : W;
            for (int p = 0; p < lw; p++) begin
                in_href  = 1'b1;
                in_raw   = 8'(l * 16 + p);
                cfg_stop = (l == stop_l && p == 3);
                tick();
            end
            cfg_stop = 1'b0;
            in_href  = 1'b0;
            in_raw   = '0;
            tick(4);
        end
    endtask

    task automatic send_frame(input int short_l, input int stop_l);
        vsync_pulse();
        send_lines(short_l, stop_l);
    endtask

    function automatic int count_flag(input int which);
        int n;
        n = 0;
        foreach (beats[i]) begin
            if (which == 0 && beats[i].sof) n++;
            if (which == 1 && beats[i].eol) n++;
            if (which == 2 && beats[i].eof) n++;
        end
        return n;
    endfunction

    vec_t vecs[8];

    initial begin
        vecs[0] = '{x:0, y:0, w:8, h:4, short_l:-1, exp_beats:32, exp_err:1'b0};
        vecs[1] = '{x:2, y:1, w:3, h:2, short_l:-1, exp_beats:6,  exp_err:1'b0};
        vecs[2] = '{x:0, y:0, w:8, h:6, short_l:-1, exp_beats:32, exp_err:1'b1};
        vecs[3] = '{x:0, y:0, w:0, h:4, short_l:-1, exp_beats:0,  exp_err:1'b0};
        vecs[4] = '{x:0, y:0, w:8, h:0, short_l:-1, exp_beats:0,  exp_err:1'b0};
        vecs[5] = '{x:6, y:3, w:4, h:1, short_l:-1, exp_beats:2,  exp_err:1'b1};
        vecs[6] = '{x:7, y:3, w:1, h:1, short_l:-1, exp_beats:1,  exp_err:1'b0};
        vecs[7] = '{x:0, y:0, w:8, h:4, short_l:2,  exp_beats:31, exp_err:1'b1};

        tick(3);
        chk("reset_flags", {out_valid, out_sof, out_eol, out_eof, busy, frame_done, err_short}, 0);
        chk("reset_data", out_data, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        reset_n = 1'b1;
        tick(2);

        // Single-shot captures over the crop table.
        for (int v = 0; v < 8; v++) begin
            cfg_crop_x = CW'(vecs[v].x);
            cfg_crop_y = CW'(vecs[v].y);
            cfg_crop_w = CW'(vecs[v].w);
            cfg_crop_h = CW'(vecs[v].h);
            cfg_continuous = 1'b0;
            beats.delete();
            expq.delete();
            fd_cnt = 0;
            for (int l = 0; l < H; l++) begin
                int lw;
                lw = (l == vecs[v].short_l) ? W - 1 : W;
                for (int p = 0; p < lw; p++) begin
                    if (l >= vecs[v].y && l < vecs[v].y + vecs[v].h &&
                        p >= vecs[v].x && p < vecs[v].x + vecs[v].w) begin
                        beat_t b;
                        b.sof  = (l == vecs[v].y && p == vecs[v].x);
                        b.eol  = (p == vecs[v].x + vecs[v].w - 1);
                        b.eof  = b.eol && (l == vecs[v].y + vecs[v].h - 1);
                        b.data = 8'(l * 16 + p);
                        expq.push_back(b);
                    end
                end
            end
            pulse_start();
            chk("start_busy", busy, 1);
            chk("start_clears_err", err_short, 0);
            send_frame(vecs[v].short_l, -1);
            vsync_pulse();
            tick(6);
            exp_fc++;
            chk("beat_count", beats.size(), vecs[v].exp_beats);
            chk("model_count", expq.size(), vecs[v].exp_beats);
            for (int i = 0; i < beats.size() && i < expq.size(); i++)
                chk($sformatf("vec%0d_beat%0d", v, i), int'(beats[i]), int'(expq[i]));
            chk("frame_done_pulses", fd_cnt, 1);
            chk("frame_cnt", frame_cnt, exp_fc);
            chk("busy_after", busy, 0);
            chk("err_short", err_short, vecs[v].exp_err);
            $display("vec %0d crop=(%0d,%0d,%0d,%0d) beats=%0d frame_cnt=%0d err_short=%0d",
                     v, vecs[v].x, vecs[v].y, vecs[v].w, vecs[v].h, beats.size(), frame_cnt, err_short);
        end

        // Continuous capture, stop requested mid frame 2: frame 2 still completes.
        cfg_crop_x = 0; cfg_crop_y = 0; cfg_crop_w = 8; cfg_crop_h = 4;
        cfg_continuous = 1'b1;
        beats.delete();
        fd_cnt = 0;
        pulse_start();
        send_frame(-1, -1);
        send_frame(-1, 1);
        vsync_pulse();
        tick(6);
        exp_fc += 2;
        chk("cont_beats", beats.size(), 64);
        chk("cont_sof", count_flag(0), 2);
        chk("cont_eol", count_flag(1), 8);
        chk("cont_eof", count_flag(2), 2);
        chk("cont_frame_done", fd_cnt, 2);
        chk("cont_frame_cnt", frame_cnt, exp_fc);
        chk("cont_busy", busy, 0);
        send_frame(-1, -1);
        vsync_pulse();
        tick(6);
        chk("post_stop_beats", beats.size(), 64);
        chk("post_stop_done", fd_cnt, 2);
        $display("continuous stop: beats=%0d frame_done=%0d frame_cnt=%0d", beats.size(), fd_cnt, frame_cnt);

        // Stop while armed returns to IDLE without a frame.
        cfg_continuous = 1'b0;
        beats.delete();
        fd_cnt = 0;
        pulse_start();
        tick(3);
        chk("arm_busy", busy, 1);
        pulse_stop();
        chk("arm_stop_idle", busy, 0);
        send_frame(-1, -1);
        vsync_pulse();
        tick(6);
        chk("arm_stop_no_done", fd_cnt, 0);
        chk("arm_stop_no_beats", beats.size(), 0);
        chk("arm_stop_frame_cnt", frame_cnt, exp_fc);
        $display("stop in ARM: busy=%0d frame_done=%0d beats=%0d", busy, fd_cnt, beats.size());

        // Start+stop together: start taken in IDLE, stop wins in ARM.
        cfg_start = 1'b1; cfg_stop = 1'b1;
        tick();
        chk("idle_start_stop", busy, 1);
        tick();
        cfg_start = 1'b0; cfg_stop = 1'b0;
        chk("arm_start_stop", busy, 0);
        $display("start+stop: ARM entered then left, busy=%0d", busy);

        // Reset in the middle of a line.
        beats.delete();
        fd_cnt = 0;
        pulse_start();
        vsync_pulse();
        for (int p = 0; p < 8; p++) begin
            in_href = 1'b1; in_raw = 8'(p); tick();
        end
        in_href = 1'b0; tick(4);
        for (int p = 0; p < 4; p++) begin
            in_href = 1'b1; in_raw = 8'(16 + p); tick();
        end
        reset_n = 1'b0;
        @(negedge xclk);
        chk("rst_mid_flags", {out_valid, out_sof, out_eol, out_eof, busy, frame_done, err_short}, 0);
        chk("rst_mid_data", out_data, 0);
        chk("rst_mid_frame_cnt", frame_cnt, 0);
        in_href = 1'b0; in_raw = '0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        chk("rst_mid_no_done", fd_cnt, 0);
        exp_fc = 0;
        beats.delete();
        pulse_start();
        send_lines(-1, -1);
        chk("rearm_waits_vsync", beats.size(), 0);
        send_frame(-1, -1);
        vsync_pulse();
        tick(6);
        exp_fc++;
        chk("rearm_beats", beats.size(), 32);
        chk("rearm_done", fd_cnt, 1);
        chk("rearm_frame_cnt", frame_cnt, exp_fc);
        $display("reset mid-line: beats after rearm=%0d frame_cnt=%0d", beats.size(), frame_cnt);

        chk("data_zero_when_idle", zero_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
